ucode_seq: RTL



---
 rtl/ucode_seq_if.sv | 31 +++
 rtl/ucode_seq.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ucode_seq_if.sv
// Bundle between the instruction decoder / microcode ROM / microcode register
// and the microcode address sequencer.
//
// Entry handshake: ucode_start is "valid" and carries ucode_entry; !ucode_busy
// is "ready". A routine is accepted on a rising clk edge where ucode_start=1,
// ucode_busy=0 and ucode_exc=0. The decoder holds ucode_start and ucode_entry
// stable until it sees the acceptance (ucode_busy rising).
interface ucode_seq_if;
   logic        ucode_start;
   logic [8:0]  ucode_entry;
   logic [11:0] u_f18;
   logic        u_zero;
   logic        ie_stall_ucode;
   logic        ucode_exc;
   logic [8:0]  rom_addr;
   logic        sel_fxx_default;
   logic        ucode_busy;
   logic        ucode_done;

   // Decoder/IE side: drives requests and branch inputs, observes controls.
   modport master (
      output ucode_start, ucode_entry, u_f18, u_zero, ie_stall_ucode, ucode_exc,
      input  rom_addr, sel_fxx_default, ucode_busy, ucode_done
   );

   // Sequencer side.
   modport slave (
      input  ucode_start, ucode_entry, u_f18, u_zero, ie_stall_ucode, ucode_exc,
      output rom_addr, sel_fxx_default, ucode_busy, ucode_done
   );
endinterface

// File: rtl/ucode_seq.sv
// Microcode address sequencer.
// Computes the next microcode ROM address every cycle from the branch field
// (u_f18 = {op[2:0], target[8:0]}) of the microinstruction held in the
// microcode register, and drives the hold/squash select for that register.
// Optional feature macro: UCODE_CALL_EN adds a one-deep return register so
// CALL/RET work as subroutine linkage; without it CALL acts as JMP and RET
// acts as END.
module ucode_seq (
   input  logic       clk,
   input  logic       reset_l,
   ucode_seq_if.slave bus,
   output logic       state_dbg   // 1 while in RUN
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [2:0] OP_SEQ  = 3'b000;
   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_BZ   = 3'b010;
   localparam logic [2:0] OP_BNZ  = 3'b011;
   localparam logic [2:0] OP_END  = 3'b100;
   localparam logic [2:0] OP_CALL = 3'b101;
   localparam logic [2:0] OP_RET  = 3'b110;

   state_e      state_q, state_d;
   logic [8:0]  upc_q, upc_d;
   logic        done_q, done_d;
`ifdef UCODE_CALL_EN
   logic [8:0]  ret_q, ret_d;
`endif

   logic [2:0]  op;
   logic [8:0]  target;
   logic [8:0]  upc_inc;
   logic [8:0]  next_addr;
   logic        ends;
   logic [8:0]  rom_addr_c;
   logic        sel_c;

   assign op      = bus.u_f18[11:9];
   assign target  = bus.u_f18[8:0];
   assign upc_inc = upc_q + 9'd1;   // 9-bit wrap: 1FF -> 000

   // Next-state, next-address and register-select decode.
   always_comb begin
      state_d    = state_q;
      upc_d      = upc_q;
      done_d     = 1'b0;
`ifdef UCODE_CALL_EN
      ret_d      = ret_q;
`endif
      next_addr  = upc_inc;
      ends       = 1'b0;
      rom_addr_c = 9'h000;
      sel_c      = 1'b1;

      if (bus.ucode_exc) begin
         // Abort: squash the register, drop to IDLE, no done pulse.
         state_d = IDLE;
         upc_d   = 9'h000;
      end else if (state_q == IDLE) begin
         if (bus.ucode_start) begin
            rom_addr_c = bus.ucode_entry;
            sel_c      = 1'b0;
            upc_d      = bus.ucode_entry;
            state_d    = RUN;
         end
      end else if (bus.ie_stall_ucode) begin
         // Hold: re-read the current microinstruction, branch not evaluated.
         rom_addr_c = upc_q;
         sel_c      = 1'b0;
      end else begin
         case (op)
            OP_SEQ:  next_addr = upc_inc;
            OP_JMP:  next_addr = target;
            OP_BZ:   next_addr = bus.u_zero ? target : upc_inc;
            OP_BNZ:  next_addr = bus.u_zero ? upc_inc : target;
            OP_END:  ends = 1'b1;
`ifdef UCODE_CALL_EN
            OP_CALL: begin
               next_addr = target;
               ret_d     = upc_inc;   // one-deep: a nested CALL overwrites
            end
            OP_RET:  next_addr = ret_q;
`else
            OP_CALL: next_addr = target;
            OP_RET:  ends = 1'b1;
`endif
            default: next_addr = upc_inc;   // reserved op behaves as SEQ
         endcase

         if (ends) begin
            rom_addr_c = 9'h000;
            sel_c      = 1'b1;
            upc_d      = 9'h000;
            state_d    = IDLE;
            done_d     = 1'b1;
         end else begin
            rom_addr_c = next_addr;
            sel_c      = 1'b0;
            upc_d      = next_addr;
         end
      end
   end

   // State, micro-PC and done-pulse registers.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= IDLE;
         upc_q   <= 9'h000;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         upc_q   <= upc_d;
         done_q  <= done_d;
      end
   end

`ifdef UCODE_CALL_EN
   // Return-address register for one-deep CALL/RET.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         ret_q <= 9'h000;
      end else begin
         ret_q <= ret_d;
      end
   end
`endif

   assign bus.rom_addr        = rom_addr_c;
   assign bus.sel_fxx_default = sel_c;
   assign bus.ucode_busy      = (state_q == RUN);
   assign bus.ucode_done      = done_q;
   assign state_dbg           = (state_q == RUN);

endmodule
